pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period, high time and normalized duty cycle in the same encoding the PWM generator consumes: period in clk cycles, duty as high·65536/period. Sits beside the PWM generator in the GPIO peripheral, on input-capture pins. Synchronizes the pin, detects edges and counts cycles between them. Converts each completed period to a 16-bit duty value with a sequential divider.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_duty_div.sv | 79 +++++++
 rtl/pwm_capture.sv | 176 +++++++++++++++++
 tb/tb_pwm_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM capture block.
//   CNT_W_DEF : default counter/result width in clk cycles
//   DUTY_FS   : duty full-scale value (duty = high * DUTY_FS / period)
//   DUTY_W    : width of a duty value
//   pwm_state_e : capture FSM states
package pwm_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DUTY_FS   = 65536;
    localparam int unsigned DUTY_W    = $clog2(DUTY_FS);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } pwm_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider producing a DUTY_W-bit quotient with a
// fixed DUTY_W-iteration latency.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle pulse, loads dividend/divisor
//   abort      : cancels a running division (no done pulse)
//   dividend   : {high, DUTY_W zeros}; upper part must be below divisor
//   divisor    : period, non-zero
//   quotient   : valid only while done is high
//   busy       : high from the start cycle through the last iteration
//   done       : high during the last iteration cycle
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W+DUTY_W-1:0] dividend,
    input  logic [CNT_W-1:0]        divisor,
    output logic [DUTY_W-1:0]       quotient,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ITER_W = $clog2(DUTY_W);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DUTY_W - 1);

    logic              running;
    logic [ITER_W-1:0] iter;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  dvsr;
    logic [DUTY_W-1:0] quo_sh;

    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    rem_full;
    logic              ge;
    logic [DUTY_W-1:0] quo_next;

    // Upper dividend bits start as the partial remainder, so only the low
    // DUTY_W bits need shifting in; quotient bits fill quo_sh from the LSB.
    always_comb begin
        trial    = {rem, quo_sh[DUTY_W-1]};
        ge       = (trial >= {1'b0, dvsr});
        rem_full = ge ? (trial - {1'b0, dvsr}) : trial;
        quo_next = {quo_sh[DUTY_W-2:0], ge};
    end

    assign quotient = quo_next;
    assign busy     = running | start;
    assign done     = running && (iter == LAST_ITER) && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            iter    <= '0;
            rem     <= '0;
            dvsr    <= '0;
            quo_sh  <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            iter    <= '0;
            rem     <= dividend[CNT_W+DUTY_W-1:DUTY_W];
            quo_sh  <= dividend[DUTY_W-1:0];
            dvsr    <= divisor;
        end else if (running) begin
            rem    <= rem_full[CNT_W-1:0];
            quo_sh <= quo_next;
            iter   <= iter + 1'b1;
            if (iter == LAST_ITER) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of a PWM input pin.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : capture enable; low returns to IDLE and aborts division
//   pwm_in     : asynchronous PWM pin
//   period_o   : last valid period, clk cycles rise-to-rise
//   high_o     : last valid high time, clk cycles rise-to-fall
//   duty_o     : floor(high_o * 65536 / period_o)
//   meas_valid : one-cycle pulse when the three results update
//   timeout    : one-cycle pulse when the counter saturates without an edge
//   missed     : one-cycle pulse when a period completes while dividing
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  high_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              meas_valid,
    output logic              timeout,
    output logic              missed
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // SYNC_STAGES synchronizer flops plus one delayed copy for edge detect.
    logic [SYNC_STAGES:0] sync;
    logic                 rise;
    logic                 fall;

    pwm_state_e state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  high_cap;
    logic [CNT_W-1:0]  period_lat;
    logic [CNT_W-1:0]  high_lat;
    logic              load_cnt;
    logic              fall_take;
    logic              complete;
    logic              to_hit;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quotient;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-1:0], pwm_in};
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES];
    assign fall = ~sync[SYNC_STAGES-1] & sync[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edges take priority over a same-cycle counter saturation.
    always_comb begin
        state_next = state;
        load_cnt   = 1'b0;
        fall_take  = 1'b0;
        complete   = 1'b0;
        to_hit     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = HIGH;
                        load_cnt   = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = LOW;
                        fall_take  = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        state_next = ARM;
                        to_hit     = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_next = HIGH;
                        load_cnt   = 1'b1;
                        complete   = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        state_next = ARM;
                        to_hit     = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            high_cap   <= '0;
            period_lat <= '0;
            high_lat   <= '0;
            div_start  <= 1'b0;
            period_o   <= '0;
            high_o     <= '0;
            duty_o     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            missed     <= 1'b0;
        end else begin
            div_start  <= 1'b0;
            missed     <= 1'b0;
            timeout    <= to_hit;
            meas_valid <= div_done;

            if (load_cnt) begin
                cnt <= CNT_W'(1);
            end else if ((state == HIGH || state == LOW) && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (fall_take) begin
                high_cap <= cnt;
            end

            // Latched operands stay stable while dividing because a
            // completion during busy is dropped rather than latched.
            if (complete) begin
                if (div_busy) begin
                    missed <= 1'b1;
                end else begin
                    period_lat <= cnt;
                    high_lat   <= high_cap;
                    div_start  <= 1'b1;
                end
            end

            if (div_done) begin
                period_o <= period_lat;
                high_o   <= high_lat;
                duty_o   <= div_quotient;
            end
        end
    end

    pwm_duty_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (~enable),
        .dividend ({high_lat, {DUTY_W{1'b0}}}),
        .divisor  (period_lat),
        .quotient (div_quotient),
        .busy     (div_busy),
        .done     (div_done)
    );

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture. Stimulus pushes the
// expected measurement for each completed period; a negedge monitor pops and
// compares on every meas_valid and counts missed/timeout pulses.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              pwm_in = 1'b0;
    logic [CNT_W-1:0]  period_o;
    logic [CNT_W-1:0]  high_o;
    logic [15:0]       duty_o;
    logic              meas_valid;
    logic              timeout;
    logic              missed;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] high;
        logic [15:0] duty;
    } meas_t;

    meas_t exp_q[$];
    meas_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    missed_cnt = 0;
    int    timeout_cnt = 0;
    int    base_missed;
    int    base_timeout;

    always #5 clk = ~clk;

    pwm_capture #(
        .SYNC_STAGES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_o   (period_o),
        .high_o     (high_o),
        .duty_o     (duty_o),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .missed     (missed)
    );

    always @(negedge clk) begin
        if (missed === 1'b1) missed_cnt++;
        if (timeout === 1'b1) timeout_cnt++;
        if (meas_valid !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL meas_unexpected actual p=%0d h=%0d d=%h required none",
                         period_o, high_o, duty_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (period_o !== mon_e.period || high_o !== mon_e.high || duty_o !== mon_e.duty) begin
                    failures++;
                    $display("FAIL meas_result actual p=%0d h=%0d d=%h required p=%0d h=%0d d=%h",
                             period_o, high_o, duty_o, mon_e.period, mon_e.high, mon_e.duty);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_meas(input int per, input int hi, input int duty, input int n);
        meas_t m;
        m.period = 16'(per);
        m.high   = 16'(hi);
        m.duty   = 16'(duty);
        for (int i = 0; i < n; i++) exp_q.push_back(m);
    endtask

    task automatic run_pwm(input int per, input int hi, input int nrises);
        for (int k = 0; k < nrises; k++) begin
            pwm_in = 1'b1;
            wait_cyc(hi);
            pwm_in = 1'b0;
            wait_cyc(per - hi);
        end
    endtask

    task automatic chk_results(input string name, input int per, input int hi, input int duty);
        chk({name, "_period"}, 32'(period_o), 32'(per));
        chk({name, "_high"}, 32'(high_o), 32'(hi));
        chk({name, "_duty"}, 32'(duty_o), 32'(duty));
    endtask

    task automatic rearm();
        enable = 1'b0;
        wait_cyc(3);
        enable = 1'b1;
        wait_cyc(3);
        base_missed  = missed_cnt;
        base_timeout = timeout_cnt;
    endtask

    initial begin
        wait_cyc(3);
        chk_results("reset", 0, 0, 0);
        chk("reset_meas_valid", 32'(meas_valid), 0);
        chk("reset_timeout", 32'(timeout), 0);
        chk("reset_missed", 32'(missed), 0);
        chk("reset_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        rst_n = 1'b1;
        wait_cyc(2);
        rearm();
        chk("armed_state", 32'(int'(dut.state)), 32'(int'(ARM)));

        // Period 100, high 25: six rises give five completions.
        push_meas(100, 25, 16'h4000, 5);
        run_pwm(100, 25, 6);
        wait_cyc(10);
        chk("p100_drained", 32'(exp_q.size()), 0);
        chk("p100_missed", 32'(missed_cnt - base_missed), 0);
        chk("p100_timeout", 32'(timeout_cnt - base_timeout), 0);

        // Period 10, high 3: completions alternate measured / missed.
        rearm();
        chk_results("hold_after_disable", 100, 25, 16'h4000);
        push_meas(10, 3, 16'h4CCC, 3);
        run_pwm(10, 3, 7);
        wait_cyc(25);
        chk("p10_drained", 32'(exp_q.size()), 0);
        chk("p10_missed", 32'(missed_cnt - base_missed), 3);
        chk("p10_timeout", 32'(timeout_cnt - base_timeout), 0);

        // Pin stuck high after one rise: counter saturates.
        rearm();
        pwm_in = 1'b1;
        wait_cyc(70000);
        chk("stuck_timeout", 32'(timeout_cnt - base_timeout), 1);
        chk("stuck_state", 32'(int'(dut.state)), 32'(int'(ARM)));
        chk("stuck_missed", 32'(missed_cnt - base_missed), 0);
        chk_results("stuck_hold", 10, 3, 16'h4CCC);
        pwm_in = 1'b0;
        wait_cyc(10);
        chk("stuck_fall_ignored", 32'(int'(dut.state)), 32'(int'(ARM)));
        push_meas(100, 25, 16'h4000, 1);
        run_pwm(100, 25, 2);
        wait_cyc(20);
        chk("recover_drained", 32'(exp_q.size()), 0);

        // Enable dropped while the divider is working.
        rearm();
        pwm_in = 1'b1;
        wait_cyc(10);
        pwm_in = 1'b0;
        wait_cyc(30);
        pwm_in = 1'b1;
        wait_cyc(8);
        enable = 1'b0;
        wait_cyc(30);
        chk("abort_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        chk_results("abort_hold", 100, 25, 16'h4000);
        pwm_in = 1'b0;
        wait_cyc(3);
        enable = 1'b1;
        wait_cyc(3);
        push_meas(50, 20, 16'h6666, 1);
        run_pwm(50, 20, 2);
        wait_cyc(25);
        chk("reenable_drained", 32'(exp_q.size()), 0);

        // Reset pulse in the middle of a high phase.
        pwm_in = 1'b1;
        wait_cyc(10);
        chk("pre_reset_state", 32'(int'(dut.state)), 32'(int'(HIGH)));
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n  = 1'b1;
        enable = 1'b0;
        chk_results("midrst", 0, 0, 0);
        chk("midrst_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        chk("midrst_flags", {29'd0, meas_valid, timeout, missed}, 0);
        wait_cyc(5);
        pwm_in = 1'b0;
        wait_cyc(5);
        chk("postrst_idle", 32'(int'(dut.state)), 32'(int'(IDLE)));
        chk_results("postrst_hold", 0, 0, 0);

        // Period 18, high 9: divider is free at every completion.
        rearm();
        push_meas(18, 9, 16'h8000, 5);
        run_pwm(18, 9, 6);
        wait_cyc(25);
        chk("p18_drained", 32'(exp_q.size()), 0);
        chk("p18_missed", 32'(missed_cnt - base_missed), 0);
        chk("p18_timeout", 32'(timeout_cnt - base_timeout), 0);
        chk_results("p18_final", 18, 9, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
